// File: rtl/cvp14_mem_responder.sv
// rtl/cvp14_mem_responder.sv - CVP14 bus memory responder with fixed read latency, error flag and request counters
module cvp14_mem_responder #(
    parameter int AW  = 10,
    parameter int LAT = 2
) (
    input  logic        Clk1,
    input  logic        Reset,
    input  logic [15:0] Addr,
    input  logic        RD,
    input  logic        WR,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        RdValid,
    output logic        Err,
    output logic [7:0]  RdCount,
    output logic [7:0]  WrCount
);

    logic [15:0]           mem_q [1 << AW];
    logic                  in_range;
    logic                  is_rd;
    logic                  is_wr;
    logic                  illegal;
    logic [15:0]           rd_data;

    logic [LAT-1:0]        pv_q, pv_d;
    logic [LAT-1:0][15:0]  pd_q, pd_d;
    logic                  err_q, err_d;
    logic [7:0]            rd_count_q, rd_count_d;
    logic [7:0]            wr_count_q, wr_count_d;

    always_comb begin
        in_range = ((Addr >> AW) == 16'h0000);
        is_rd    = RD & ~WR;
        is_wr    = WR & ~RD;
        illegal  = RD & WR;
        rd_data  = in_range ? mem_q[Addr[AW-1:0]] : 16'h0000;
    end

    // Array has no reset so committed writes survive a Reset pulse.
    always_ff @(posedge Clk1) begin
        if (is_wr && in_range) begin
            mem_q[Addr[AW-1:0]] <= DataIn;
        end
    end

    // The last stage doubles as the DataOut register, which only loads on a valid entry.
    always_comb begin
        pv_d    = '0;
        pd_d    = pd_q;
        pv_d[0] = is_rd;
        pd_d[0] = rd_data;
        for (int k = 1; k < LAT; k++) begin
            pv_d[k] = pv_q[k-1];
            pd_d[k] = pd_q[k-1];
        end
        if (!pv_d[LAT-1]) begin
            pd_d[LAT-1] = pd_q[LAT-1];
        end
    end

    always_comb begin
        rd_count_d = rd_count_q + {7'd0, is_rd};
        wr_count_d = wr_count_q + {7'd0, is_wr};
        err_d      = err_q | illegal | ((is_rd | is_wr) & ~in_range);
    end

    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            pv_q       <= '0;
            pd_q       <= '0;
            err_q      <= 1'b0;
            rd_count_q <= 8'h00;
            wr_count_q <= 8'h00;
        end else begin
            pv_q       <= pv_d;
            pd_q       <= pd_d;
            err_q      <= err_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign DataOut = pd_q[LAT-1];
    assign RdValid = pv_q[LAT-1];
    assign Err     = err_q;
    assign RdCount = rd_count_q;
    assign WrCount = wr_count_q;

endmodule

// File: tb/tb_cvp14_mem_responder.sv
// tb/tb_cvp14_mem_responder.sv - scoreboard bench driving LAT=1/2/4 responders in lockstep
module tb_cvp14_mem_responder;

    typedef struct {
        logic [15:0] d;
        int          c;
    } rd_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [15:0] din;

    logic [15:0] d1, d2, d4;
    logic        v1, v2, v4;
    logic        e1, e2, e4;
    logic [7:0]  rc1, rc2, rc4;
    logic [7:0]  wc1, wc2, wc4;

    logic [2:0]  vv;
    logic [15:0] dd [3];
    int          lat_of [3] = '{1, 2, 4};
    int          ptr [3] = '{0, 0, 0};

    rd_t         sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_rd = 8'h00;
    logic [7:0]  exp_wr = 8'h00;
    logic        exp_err = 1'b0;

    cvp14_mem_responder #(.AW(10), .LAT(1)) u_lat1 (
        .Clk1(clk), .Reset(rst_n), .Addr(addr), .RD(rd), .WR(wr), .DataIn(din),
        .DataOut(d1), .RdValid(v1), .Err(e1), .RdCount(rc1), .WrCount(wc1)
    );
    cvp14_mem_responder #(.AW(10), .LAT(2)) u_lat2 (
        .Clk1(clk), .Reset(rst_n), .Addr(addr), .RD(rd), .WR(wr), .DataIn(din),
        .DataOut(d2), .RdValid(v2), .Err(e2), .RdCount(rc2), .WrCount(wc2)
    );
    cvp14_mem_responder #(.AW(10), .LAT(4)) u_lat4 (
        .Clk1(clk), .Reset(rst_n), .Addr(addr), .RD(rd), .WR(wr), .DataIn(din),
        .DataOut(d4), .RdValid(v4), .Err(e4), .RdCount(rc4), .WrCount(wc4)
    );

    assign vv = {v4, v2, v1};
    assign dd[0] = d1;
    assign dd[1] = d2;
    assign dd[2] = d4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int j = 0; j < 3; j++) begin
            if (vv[j] || (ptr[j] < sb.size() && sb[ptr[j]].c + lat_of[j] - 1 <= cyc)) begin
                checks++;
                assert (vv[j] === 1'b1) else begin
                    errors++;
                    $error("FAIL rdvalid_missing_lat%0d: observed RdValid=%b expected 1 at cycle %0d", lat_of[j], vv[j], cyc);
                end
                if (vv[j]) begin
                    checks++;
                    assert (ptr[j] < sb.size()) else begin
                        errors++;
                        $error("FAIL rdvalid_unexpected_lat%0d: observed pulse at cycle %0d expected none", lat_of[j], cyc);
                    end
                    if (ptr[j] < sb.size()) begin
                        checks++;
                        assert (dd[j] === sb[ptr[j]].d) else begin
                            errors++;
                            $error("FAIL rdata_lat%0d: observed %h expected %h", lat_of[j], dd[j], sb[ptr[j]].d);
                        end
                        checks++;
                        assert (cyc === sb[ptr[j]].c + lat_of[j] - 1) else begin
                            errors++;
                            $error("FAIL rdlatency_lat%0d: observed cycle %0d expected %0d", lat_of[j], cyc, sb[ptr[j]].c + lat_of[j] - 1);
                        end
                    end
                end
                if (ptr[j] < sb.size()) ptr[j]++;
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] exp);
        @(posedge clk);
        #1;
        rd   = r;
        wr   = w;
        addr = a;
        din  = d;
        if (r && !w) begin
            sb.push_back('{d: exp, c: cyc + 1});
            exp_rd = exp_rd + 8'd1;
        end
        if (w && !r) exp_wr = exp_wr + 8'd1;
        if (r && w) exp_err = 1'b1;
        else if ((r || w) && (a >> 10) != 16'h0000) exp_err = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    endtask

    task automatic chk_status(input string tag);
        @(negedge clk);
        chk({tag, "_rdcount"}, {8'h00, rc2}, {8'h00, exp_rd});
        chk({tag, "_wrcount"}, {8'h00, wc2}, {8'h00, exp_wr});
        chk({tag, "_err"}, {15'd0, e2}, {15'd0, exp_err});
        chk({tag, "_rdcount_lat4"}, {8'h00, rc4}, {8'h00, exp_rd});
    endtask

    initial begin
        rst_n = 1'b0;
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = 16'h0000;
        din   = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_dataout", d2, 16'h0000);
        chk("reset_rdvalid", {13'd0, v4, v2, v1}, 16'h0000);
        chk("reset_err", {13'd0, e4, e2, e1}, 16'h0000);
        chk("reset_rdcount", {8'h00, rc1}, 16'h0000);
        chk("reset_wrcount", {8'h00, wc4}, 16'h0000);
        #1 rst_n = 1'b1;

        bus(1'b0, 1'b1, 16'h0003, 16'hA5A5, 16'h0000);
        bus(1'b0, 1'b1, 16'h0004, 16'h1234, 16'h0000);
        bus(1'b1, 1'b0, 16'h0003, 16'h0000, 16'hA5A5);
        bus(1'b1, 1'b0, 16'h0004, 16'h0000, 16'h1234);
        idle(6);
        chk_status("basic");

        bus(1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000);
        bus(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
        idle(1);
        bus(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
        bus(1'b0, 1'b1, 16'h0010, 16'h0001, 16'h0000);
        idle(6);
        chk_status("raw_war");

        bus(1'b1, 1'b1, 16'h0010, 16'h0BAD, 16'h0000);
        idle(6);
        chk_status("illegal");
        bus(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0001);
        idle(6);
        chk_status("illegal_sticky");

        bus(1'b1, 1'b0, 16'h0003, 16'h0000, 16'hA5A5);
        bus(1'b1, 1'b1, 16'h0004, 16'h7777, 16'h0000);
        bus(1'b1, 1'b0, 16'h0004, 16'h0000, 16'h1234);
        idle(6);

        bus(1'b1, 1'b0, 16'h0400, 16'h0000, 16'h0000);
        idle(6);
        chk_status("oor_read");

        bus(1'b1, 1'b0, 16'h0003, 16'h0000, 16'hA5A5);
        bus(1'b1, 1'b0, 16'h0004, 16'h0000, 16'h1234);
        bus(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0001);
        @(negedge clk);
        #1;
        rd    = 1'b0;
        wr    = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset_rdvalid", {13'd0, v4, v2, v1}, 16'h0000);
        chk("midreset_dataout", d2, 16'h0000);
        chk("midreset_err", {13'd0, e4, e2, e1}, 16'h0000);
        chk("midreset_rdcount", {8'h00, rc2}, 16'h0000);
        sb.delete();
        ptr = '{0, 0, 0};
        exp_rd  = 8'h00;
        exp_wr  = 8'h00;
        exp_err = 1'b0;
        #4 rst_n = 1'b1;
        idle(6);
        bus(1'b1, 1'b0, 16'h0003, 16'h0000, 16'hA5A5);
        idle(6);
        chk_status("after_reset");

        for (int i = 0; i < 256; i++) bus(1'b0, 1'b1, 16'(i), 16'(i) ^ 16'h5555, 16'h0000);
        idle(1);
        chk_status("wrap");
        chk("wrap_zero", {8'h00, wc1}, 16'h0000);
        bus(1'b1, 1'b0, 16'h0005, 16'h0000, 16'h5550);
        bus(1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h55AA);
        idle(8);

        for (int j = 0; j < 3; j++) begin
            checks++;
            assert (ptr[j] === sb.size()) else begin
                errors++;
                $error("FAIL drained_lat%0d: observed %0d delivered expected %0d", lat_of[j], ptr[j], sb.size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cvp14_mem_responder.md
# cvp14_mem_responder

Memory responder for the CVP14 processor bus. It accepts the processor's RD/WR/Addr/DataOut requests, services them from a local word-addressed array, and returns read data with a fixed, parameterised pipeline latency. It can stand in for the DRAM model in system benches, or act as a synthesizable on-chip memory behind the same bus. It also reports bus protocol errors and keeps request counters.

## Interface
- AW, default 10: address bits decoded; array depth is 2^AW 16-bit words (legal 4..16).
- LAT, default 2: read latency in clock cycles (legal 1..4).
- Clk1  input  1  sole clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Addr  input  16  word address from the processor.
- RD  input  1  read request, sampled each rising edge.
- WR  input  1  write request, sampled each rising edge.
- DataIn  input  16  write data from the processor (the processor's DataOut).
- DataOut  output  16  read data to the processor (the processor's DataIn).
- RdValid  output  1  high for exactly the cycles in which DataOut carries a completed read.
- Err  output  1  sticky protocol/range error flag.
- RdCount  output  8  count of accepted reads, wraps 255->0.
- WrCount  output  8  count of accepted writes, wraps 255->0.

## Operation
- Request classes, evaluated at each rising edge:
  - Idle: RD=0, WR=0. Nothing happens.
  - Read: RD=1, WR=0.
  - Write: RD=0, WR=1.
  - Illegal: RD=1, WR=1. Both are ignored: no array update, no read issued, no counter change, Err set.
- Range: an address is in range when Addr[15:AW]==0 (always true when AW=16).
- Write, in range:
  - array[Addr[AW-1:0]] <= DataIn at the sampling edge.
  - WrCount increments.
- Write, out of range: array unchanged, WrCount increments, Err set.
- Read, in range:
  - array[Addr[AW-1:0]] is captured at the sampling edge, after any write committed at an earlier edge.
  - The captured word enters a LAT-deep valid+data pipeline.
  - RdCount increments.
- Read, out of range: 16'h0000 enters the pipeline, RdCount increments, Err set.
- Pipeline: one entry is issued per cycle, and back-to-back reads stream with no bubbles. When the pipeline output is valid, DataOut takes its data and RdValid=1. Otherwise RdValid=0 and DataOut holds its last value.
- Err is sticky and is cleared only by Reset.
- The array is not reset; its contents are undefined until written.

## Timing
- Reset asserted (Reset=0), asynchronously:
  - DataOut=16'h0000, RdValid=0, Err=0, RdCount=0, WrCount=0.
  - All pipeline valid bits cleared.
- Reset deasserted: the first request can be sampled at the first rising edge at which Reset=1.
- Read latency: a read sampled at edge E0 gives RdValid=1 and DataOut=data in the cycle following edge E(LAT-1). With LAT=1 that is the cycle immediately after the sampling edge.
- RdValid pulse: high for one cycle per read. N consecutive read cycles give N consecutive RdValid cycles.
- Write-then-read, same address:
  - Write at E0, read at E1: the read returns the new data.
  - Read at E0, write at E1: the read returns the old data.
- Counter update: counters change at the sampling edge and are visible in the next cycle.
- Reset mid-operation: in-flight reads are discarded and never produce RdValid. Array writes already committed are retained.
- Illegal cycle inside a read stream: produces a one-cycle RdValid gap, LAT cycles later.

## Test plan
- Reset, then write 16'hA5A5 to 0x0003 and 16'h1234 to 0x0004, then read 0x0003 and 0x0004 in consecutive cycles with LAT=2:
  - RdValid high for exactly 2 cycles, starting 2 cycles after the first read.
  - DataOut=16'hA5A5 then 16'h1234.
  - RdCount=2, WrCount=2, Err=0.
- Write 16'hBEEF to 0x0010, then read 0x0010 in the very next cycle:
  - DataOut=16'hBEEF.
  - Separately, read 0x0010 and then write 16'h0001 to it the next cycle: the read returns 16'hBEEF.
- RD=1 and WR=1 for one cycle at 0x0010 with DataIn=16'h0BAD:
  - Err=1 and stays 1.
  - No RdValid pulse, counters unchanged.
  - A later read of 0x0010 still returns the prior value.
- AW=10, read 0x0400:
  - DataOut=16'h0000 with RdValid=1.
  - Err=1, RdCount increments.
- Issue 3 reads, then drive Reset=0 for half a cycle before the first RdValid:
  - Outputs immediately return to reset values.
  - No RdValid afterwards.
  - Data written before reset is still readable.
- Issue 256 writes: WrCount wraps to 0. Repeat the first scenario with LAT=1 and LAT=4 and check that the RdValid offset matches.
